// File: rtl/lc3b_types.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : lc3b_types
// Brief  : Shared types for the LC-3b cache/memory path.
// Rev    : 1.0
// ---------------------------------------------------------------------------
package lc3b_types;

  localparam int unsigned c_LINE_W = 128;

  typedef logic [c_LINE_W-1:0] lc3b_c_line;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : sat_counter
// Brief  : Saturating up-counter with synchronous clear.
// Rev    : 1.0
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  // Clear beats increment; the count parks at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/l2_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : l2_arbiter
// Brief  : Round-robin I/D miss arbiter in front of the shared L2 port.
// Rev    : 1.0
// ---------------------------------------------------------------------------
module l2_arbiter
  import lc3b_types::*;
#(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              l2_read,
  output logic              l2_write,
  output logic [ADDR_W-1:0] l2_addr,
  output logic [LINE_W-1:0] l2_wdata,
  input  logic [LINE_W-1:0] l2_rdata,
  input  logic              l2_resp,
  output logic              busy,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  cnt_i_grant,
  output logic [CNT_W-1:0]  cnt_d_grant,
  output logic [CNT_W-1:0]  cnt_wait
);

  arb_state_t r_state;
  logic       r_last_d;

  logic w_d_req;
  logic w_pick_i;
  logic w_grant_i;
  logic w_grant_d;
  logic w_wait;

  // On a tie, I wins only if D took the previous grant.
  assign w_d_req   = d_read | d_write;
  assign w_pick_i  = i_read & (~w_d_req | r_last_d);
  assign w_grant_i = (r_state == IDLE) & w_pick_i;
  assign w_grant_d = (r_state == IDLE) & ~w_pick_i & w_d_req;
  assign w_wait    = (i_read & (r_state != SERVE_I)) | (w_d_req & (r_state != SERVE_D));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_last_d <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_i) begin
            r_state  <= SERVE_I;
            r_last_d <= 1'b0;
          end else if (w_grant_d) begin
            r_state  <= SERVE_D;
            r_last_d <= 1'b1;
          end
        end
        SERVE_I, SERVE_D: begin
          if (l2_resp) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    l2_read  = 1'b0;
    l2_write = 1'b0;
    l2_addr  = '0;
    l2_wdata = '0;
    i_resp   = 1'b0;
    d_resp   = 1'b0;
    case (r_state)
      SERVE_I: begin
        l2_read = 1'b1;
        l2_addr = i_addr;
        i_resp  = l2_resp;
      end
      SERVE_D: begin
        l2_read  = d_read;
        l2_write = d_write;
        l2_addr  = d_addr;
        l2_wdata = d_wdata;
        d_resp   = l2_resp;
      end
      default: begin
      end
    endcase
  end

  assign i_rdata = l2_rdata;
  assign d_rdata = l2_rdata;
  assign busy    = (r_state != IDLE);

  sat_counter #(.CNT_W(CNT_W)) u_cnt_i_grant (
    .clk     (clk),
    .reset   (reset),
    .i_inc   (w_grant_i),
    .i_clr   (clr_cnt),
    .o_count (cnt_i_grant)
  );

  sat_counter #(.CNT_W(CNT_W)) u_cnt_d_grant (
    .clk     (clk),
    .reset   (reset),
    .i_inc   (w_grant_d),
    .i_clr   (clr_cnt),
    .o_count (cnt_d_grant)
  );

  sat_counter #(.CNT_W(CNT_W)) u_cnt_wait (
    .clk     (clk),
    .reset   (reset),
    .i_inc   (w_wait),
    .i_clr   (clr_cnt),
    .o_count (cnt_wait)
  );

endmodule
`default_nettype wire

// File: tb/tb_l2_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : tb_l2_arbiter
// Brief  : Self-checking bench for l2_arbiter against a grant-level model.
// Rev    : 1.0
// ---------------------------------------------------------------------------
module tb_l2_arbiter;

  localparam int ADDR_W = 16;
  localparam int LINE_W = 128;
  localparam int CNT_W  = 16;
  localparam int SAT    = 65535;

  logic              clk = 1'b0;
  logic              reset;
  logic              i_read;
  logic [ADDR_W-1:0] i_addr;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic              l2_read;
  logic              l2_write;
  logic [ADDR_W-1:0] l2_addr;
  logic [LINE_W-1:0] l2_wdata;
  logic [LINE_W-1:0] l2_rdata;
  logic              l2_resp;
  logic              busy;
  logic              clr_cnt;
  logic [CNT_W-1:0]  cnt_i_grant;
  logic [CNT_W-1:0]  cnt_d_grant;
  logic [CNT_W-1:0]  cnt_wait;

  always #5 clk = ~clk;

  l2_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .l2_read(l2_read), .l2_write(l2_write), .l2_addr(l2_addr), .l2_wdata(l2_wdata),
    .l2_rdata(l2_rdata), .l2_resp(l2_resp),
    .busy(busy), .clr_cnt(clr_cnt),
    .cnt_i_grant(cnt_i_grant), .cnt_d_grant(cnt_d_grant), .cnt_wait(cnt_wait)
  );

  int errors = 0;
  int checks = 0;

  // Model: who holds the port (0 nobody, 1 I, 2 D), who was granted last, counters.
  int m_owner = 0;
  bit m_last_d = 1'b0;
  int m_ci = 0, m_cd = 0, m_cw = 0;
  int m_srv = 0, m_lat = 3;
  bit m_i_done = 1'b0, m_d_done = 1'b0;

  int i_left = 0, d_left = 0;
  bit auto_l2 = 1'b1, rand_mode = 1'b0, rand_lat = 1'b0, track = 1'b0, prev_busy = 1'b0;
  int order_q[$];
  int n_iresp = 0, n_dresp = 0;
  logic [LINE_W-1:0] last_i_rdata = '0;
  int exp_order[6] = '{2, 1, 2, 1, 2, 1};

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v >= SAT) ? SAT : v + 1;
  endfunction

  task automatic check_outputs;
    logic [127:0] e_rd, e_wr, e_addr, e_wdata;
    e_rd = '0; e_wr = '0; e_addr = '0; e_wdata = '0;
    if (m_owner == 1) begin
      e_rd = 128'(1'b1); e_addr = 128'(i_addr);
    end else if (m_owner == 2) begin
      e_rd = 128'(d_read); e_wr = 128'(d_write); e_addr = 128'(d_addr); e_wdata = 128'(d_wdata);
    end
    chk("busy", 128'(busy), 128'(m_owner != 0));
    chk("l2_read", 128'(l2_read), e_rd);
    chk("l2_write", 128'(l2_write), e_wr);
    chk("l2_addr", 128'(l2_addr), e_addr);
    chk("l2_wdata", 128'(l2_wdata), e_wdata);
    chk("i_resp", 128'(i_resp), 128'(m_owner == 1 && l2_resp));
    chk("d_resp", 128'(d_resp), 128'(m_owner == 2 && l2_resp));
    chk("i_rdata", 128'(i_rdata), 128'(l2_rdata));
    chk("d_rdata", 128'(d_rdata), 128'(l2_rdata));
    chk("cnt_i_grant", 128'(cnt_i_grant), 128'(m_ci));
    chk("cnt_d_grant", 128'(cnt_d_grant), 128'(m_cd));
    chk("cnt_wait", 128'(cnt_wait), 128'(m_cw));
    if (i_resp) begin n_iresp++; last_i_rdata = i_rdata; end
    if (d_resp) n_dresp++;
    if (track && busy && !prev_busy) order_q.push_back((l2_addr == i_addr) ? 1 : 2);
    prev_busy = busy;
  endtask

  task automatic model_update;
    bit dq, waiting;
    int grant;
    dq = d_read | d_write;
    m_i_done = 1'b0;
    m_d_done = 1'b0;
    if (reset) begin
      m_owner = 0; m_last_d = 1'b0; m_ci = 0; m_cd = 0; m_cw = 0;
      return;
    end
    waiting = (i_read && m_owner != 1) || (dq && m_owner != 2);
    grant = 0;
    if (m_owner == 0) begin
      if (i_read && dq) grant = m_last_d ? 1 : 2;
      else if (i_read)  grant = 1;
      else if (dq)      grant = 2;
    end
    if (clr_cnt) begin
      m_ci = 0; m_cd = 0; m_cw = 0;
    end else begin
      if (waiting)    m_cw = sat_inc(m_cw);
      if (grant == 1) m_ci = sat_inc(m_ci);
      if (grant == 2) m_cd = sat_inc(m_cd);
    end
    if (m_owner != 0 && l2_resp) begin
      m_i_done = (m_owner == 1);
      m_d_done = (m_owner == 2);
      m_owner  = 0;
    end else if (m_owner != 0) begin
      m_srv++;
    end else if (grant != 0) begin
      m_owner  = grant;
      m_last_d = (grant == 2);
      m_srv    = 0;
      if (rand_lat) m_lat = $urandom_range(0, 4);
    end
  endtask

  task automatic raise_d;
    if ($urandom_range(0, 1) == 1) d_read = 1'b1;
    else d_write = 1'b1;
    d_addr  = 16'($urandom);
    d_wdata = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic drive_next;
    if (m_i_done) begin
      if (rand_mode) begin
        i_read = 1'($urandom_range(0, 1));
        i_addr = 16'($urandom);
      end else begin
        i_left--;
        if (i_left <= 0) i_read = 1'b0;
      end
    end else if (rand_mode && !i_read && $urandom_range(0, 3) == 0) begin
      i_read = 1'b1;
      i_addr = 16'($urandom);
    end
    if (m_d_done) begin
      if (rand_mode) begin
        d_read = 1'b0; d_write = 1'b0;
        if ($urandom_range(0, 1) == 1) raise_d();
      end else begin
        d_left--;
        if (d_left <= 0) begin d_read = 1'b0; d_write = 1'b0; end
      end
    end else if (rand_mode && !(d_read || d_write) && $urandom_range(0, 3) == 0) begin
      raise_d();
    end
    if (auto_l2) begin
      l2_resp = (m_owner != 0 && m_srv >= m_lat) ||
                (rand_mode && m_owner == 0 && $urandom_range(0, 7) == 0);
      l2_rdata = rand_mode ? {$urandom, $urandom, $urandom, $urandom} : {4{32'hDEADBEEF}};
    end
    if (rand_mode) clr_cnt = ($urandom_range(0, 39) == 0);
  endtask

  task automatic cycle(input bit do_chk);
    @(negedge clk);
    if (do_chk) check_outputs();
    assert (!(d_read && d_write)) else $error("illegal stimulus: d_read and d_write together");
    assert (!((m_owner == 1 && !i_read) || (m_owner == 2 && !(d_read || d_write))))
      else $error("illegal stimulus: grantee dropped its request");
    model_update();
    @(posedge clk);
    #1;
    drive_next();
  endtask

  task automatic run_until_idle(input int budget);
    int n;
    n = 0;
    while ((i_left > 0 || d_left > 0 || m_owner != 0) && n < budget) begin
      cycle(1'b1);
      n++;
    end
    if (n >= budget) begin
      checks++;
      errors++;
      $error("FAIL timeout observed=%0d cycles expected=<%0d", n, budget);
      i_left = 0; d_left = 0;
    end
  endtask

  initial begin
    reset = 1'b1; i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; clr_cnt = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0; l2_rdata = '0; l2_resp = 1'b0;
    @(posedge clk); #1;
    cycle(1'b0); cycle(1'b0);
    reset = 1'b0;
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_l2_read", 128'(l2_read), 128'(0));
    chk("rst_cnt_wait", 128'(cnt_wait), 128'(0));
    cycle(1'b1);

    // Lone I read
    n_iresp = 0; n_dresp = 0; m_lat = 3;
    i_addr = 16'h1230; i_read = 1'b1; i_left = 1;
    cycle(1'b1);
    chk("t1_l2_read", 128'(l2_read), 128'(1));
    chk("t1_l2_addr", 128'(l2_addr), 128'(16'h1230));
    run_until_idle(20);
    chk("t1_iresp_count", 128'(n_iresp), 128'(1));
    chk("t1_dresp_count", 128'(n_dresp), 128'(0));
    chk("t1_rdata", 128'(last_i_rdata), {4{32'hDEADBEEF}});
    chk("t1_cnt_i", 128'(cnt_i_grant), 128'(1));
    cycle(1'b1);

    // Lone D write
    n_dresp = 0;
    d_addr = 16'h4560; d_wdata = {16{8'hA5}}; d_write = 1'b1; d_left = 1;
    cycle(1'b1);
    chk("t2_l2_write", 128'(l2_write), 128'(1));
    chk("t2_l2_read", 128'(l2_read), 128'(0));
    chk("t2_l2_wdata", 128'(l2_wdata), {16{8'hA5}});
    chk("t2_l2_addr", 128'(l2_addr), 128'(16'h4560));
    run_until_idle(20);
    chk("t2_dresp_count", 128'(n_dresp), 128'(1));
    chk("t2_idle_after", 128'(busy), 128'(0));
    cycle(1'b1);

    // Tie right after reset: D first, then I
    reset = 1'b1; cycle(1'b1); reset = 1'b0;
    i_addr = 16'h1110; d_addr = 16'h2220; i_read = 1'b1; d_read = 1'b1;
    i_left = 1; d_left = 1;
    cycle(1'b1);
    chk("t3_first_d", 128'(l2_addr), 128'(16'h2220));
    run_until_idle(40);
    chk("t3_cnt_wait", 128'(cnt_wait), 128'(6));
    chk("t3_cnt_d", 128'(cnt_d_grant), 128'(1));

    // Continuous contention: six alternating grants
    clr_cnt = 1'b1; cycle(1'b1); clr_cnt = 1'b0;
    order_q.delete(); track = 1'b1;
    i_addr = 16'h3330; d_addr = 16'h7770; i_read = 1'b1; d_read = 1'b1;
    i_left = 3; d_left = 3;
    run_until_idle(200);
    track = 1'b0;
    chk("t4_order_len", 128'(order_q.size()), 128'(6));
    for (int k = 0; k < 6 && k < order_q.size(); k++)
      chk($sformatf("t4_order_%0d", k), 128'(order_q[k]), 128'(exp_order[k]));
    chk("t4_cnt_d", 128'(cnt_d_grant), 128'(3));
    chk("t4_cnt_i", 128'(cnt_i_grant), 128'(3));
    cycle(1'b1);

    // Reset mid-transaction with a late L2 response
    auto_l2 = 1'b0; l2_resp = 1'b0;
    d_addr = 16'h4560; d_write = 1'b1; d_left = 1;
    cycle(1'b1); cycle(1'b1); cycle(1'b1);
    reset = 1'b1; cycle(1'b1);
    reset = 1'b0; d_write = 1'b0; d_left = 0; n_dresp = 0;
    #1;
    chk("t5_busy", 128'(busy), 128'(0));
    chk("t5_l2_write", 128'(l2_write), 128'(0));
    l2_resp = 1'b1;
    #1;
    chk("t5_late_dresp", 128'(d_resp), 128'(0));
    cycle(1'b1);
    l2_resp = 1'b0;
    chk("t5_cnt_d", 128'(cnt_d_grant), 128'(0));
    chk("t5_cnt_wait", 128'(cnt_wait), 128'(0));
    auto_l2 = 1'b1;

    // Saturation of cnt_wait: D holds the port with no response while I waits
    auto_l2 = 1'b0; l2_resp = 1'b0;
    i_addr = 16'h0100; d_addr = 16'h0200; i_read = 1'b1; d_read = 1'b1;
    i_left = 1; d_left = 1;
    while (m_cw < SAT - 1) cycle(1'b0);
    chk("t6_fffe", 128'(cnt_wait), 128'(16'hFFFE));
    cycle(1'b1);
    chk("t6_ffff", 128'(cnt_wait), 128'(16'hFFFF));
    cycle(1'b1);
    chk("t6_hold1", 128'(cnt_wait), 128'(16'hFFFF));
    cycle(1'b1);
    chk("t6_hold2", 128'(cnt_wait), 128'(16'hFFFF));
    clr_cnt = 1'b1; cycle(1'b1); clr_cnt = 1'b0;
    chk("t6_clr", 128'(cnt_wait), 128'(0));
    chk("t6_busy_kept", 128'(busy), 128'(1));
    auto_l2 = 1'b1; m_lat = 1;
    run_until_idle(60);

    // Randomized traffic against the model
    rand_mode = 1'b1; rand_lat = 1'b1;
    for (int n = 0; n < 3000; n++) cycle(1'b1);
    rand_mode = 1'b0; clr_cnt = 1'b0;
    i_left = i_read ? 1 : 0;
    d_left = (d_read || d_write) ? 1 : 0;
    run_until_idle(100);
    cycle(1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/l2_arbiter.md
Name: l2_arbiter

Overview:
- Shares one unified next-level memory port (L2 cache / physical memory, line-wide) between the instruction-cache miss path and the data-cache miss path of the pipelined LC-3b core.
- Sits between the I-cache/D-cache miss controllers and the L2 interface.
- Registered two-way round-robin grant with an FSM that holds the grant until the transaction completes.
- Drives contention and grant performance counters.

Parameters:
- ADDR_W, 16, byte address width of all requests.
- LINE_W, 128, cache line width in bits.
- CNT_W, 16, width of each saturating performance counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous active-high reset.
- i_read  in  1  I-cache line-read request; level, held until i_resp.
- i_addr  in  ADDR_W  I-cache line address.
- i_rdata  out  LINE_W  line data to I-cache.
- i_resp  out  1  one-cycle completion pulse to I-cache.
- d_read  in  1  D-cache line-read request; level, held until d_resp.
- d_write  in  1  D-cache line-write (writeback) request; level, held until d_resp.
- d_addr  in  ADDR_W  D-cache line address.
- d_wdata  in  LINE_W  D-cache writeback data.
- d_rdata  out  LINE_W  line data to D-cache.
- d_resp  out  1  one-cycle completion pulse to D-cache.
- l2_read  out  1  read strobe to L2.
- l2_write  out  1  write strobe to L2.
- l2_addr  out  ADDR_W  address to L2.
- l2_wdata  out  LINE_W  write data to L2.
- l2_rdata  in  LINE_W  read data from L2.
- l2_resp  in  1  L2 completion pulse.
- busy  out  1  high whenever state is not IDLE.
- clr_cnt  in  1  synchronous clear of all counters.
- cnt_i_grant  out  CNT_W  number of grants issued to I.
- cnt_d_grant  out  CNT_W  number of grants issued to D.
- cnt_wait  out  CNT_W  cycles in which a requester is waiting without a grant.

Behaviour:
- FSM states: IDLE, SERVE_I, SERVE_D. Register last_d (1 = last grant went to D).
- Reset values: state=IDLE, last_d=0, all counters 0. All strobes, resps, l2_addr and l2_wdata are 0 while in IDLE.
- IDLE, request handling:
  - i_read only -> SERVE_I.
  - (d_read|d_write) only -> SERVE_D.
  - Both requesting -> SERVE_I if last_d=1, else SERVE_D (round-robin; D wins the first tie after reset).
  - No request -> stay in IDLE.
  - Entering SERVE_x updates last_d and increments the matching grant counter.
- SERVE_I:
  - l2_read=1, l2_write=0, l2_addr=i_addr, l2_wdata=0.
  - i_resp=l2_resp, combinational, same cycle.
  - On l2_resp -> IDLE.
- SERVE_D:
  - l2_read=d_read, l2_write=d_write, l2_addr=d_addr, l2_wdata=d_wdata.
  - d_resp=l2_resp.
  - On l2_resp -> IDLE.
- i_rdata and d_rdata are both driven from l2_rdata. Only the granted side's resp qualifies the data.
- Latency and gaps:
  - A request seen in IDLE produces the L2 strobe on the next cycle, i.e. one cycle of added latency.
  - Every transaction ends with at least one IDLE cycle, so L2 always sees strobes low between transactions.
- l2_resp arriving in IDLE is ignored; no resp is forwarded.
- Requests are assumed legal; the bench asserts on violations:
  - d_read and d_write both high.
  - The granted requester dropping its request before resp.
- The grant never changes mid-transaction regardless of other requests.
- Counters:
  - Saturate at all-ones and do not wrap.
  - cnt_wait increments once per cycle, by 1 regardless of how many requesters are waiting, if any requester is requesting but is not the current grantee. This includes IDLE cycles.
  - clr_cnt and reset zero the counters. clr_cnt has priority over an increment in the same cycle.
  - clr_cnt does not affect the FSM.
- Reset mid-transaction: state returns to IDLE next cycle and strobes drop. The L2 must tolerate an abandoned request, and any in-flight resp is dropped.

Decomposition:
- lc3b_types package:
  - add lc3b_c_line (LINE_W logic vector), if not already present.
  - add enum arb_state_t {IDLE, SERVE_I, SERVE_D}.
- One natural sub-module: sat_counter (CNT_W, inc, clr, outputs count), instantiated three times.
- FSM and the output mux stay in l2_arbiter.

Test Plan:
- Lone I read:
  - Stimulus: i_read=1, i_addr=0x1230; L2 returns line 0xDEADBEEF_... with l2_resp 3 cycles after l2_read rises.
  - Required: l2_read rises 1 cycle after i_read; l2_addr=0x1230; i_resp pulses 1 cycle with i_rdata matching; d_resp stays 0; cnt_i_grant=1.
- Lone D write:
  - Stimulus: d_write=1, d_addr=0x4560, d_wdata=0xA5A5...
  - Required: l2_write=1, l2_wdata=0xA5A5..., l2_read=0; d_resp pulses on l2_resp; at least one IDLE cycle follows.
- Tie after reset:
  - Stimulus: i_read and d_read both raised in the same cycle.
  - Required: D is served first; I is served second with no intervening IDLE longer than 1 cycle; cnt_wait equals the length of the D transaction plus 1.
- Continuous contention:
  - Stimulus: both requesters re-request immediately after every resp for 6 transactions.
  - Required: grants alternate D,I,D,I,D,I; cnt_d_grant=3, cnt_i_grant=3.
- Reset mid-transaction:
  - Stimulus: reset during SERVE_D before l2_resp, with l2_resp arriving later.
  - Required: busy=0 and strobes=0 on the cycle after reset; the late l2_resp produces no d_resp; counters read 0.
- Counter saturation and clear:
  - Stimulus: preload or force cnt_wait to 0xFFFE, then hold i_read waiting for 3 cycles; then assert clr_cnt together with an increment condition.
  - Required: cnt_wait reads 0xFFFF and holds; after clr_cnt it reads 0.
